// File: rtl/pilha_rpn.sv
// RPN operand stack: push / pop / replace (binary-op write-back), synchronous clear, sticky error flag.
// Optional TOPO/SEGUNDO swap is compiled in when the macro PILHA_TROCA_EN is defined.
module pilha_rpn #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic                       CLOCK,
   input  logic                       RESET,
   input  logic                       ENABLE,
   input  logic                       LIMPAR,
   input  logic [1:0]                 OP,
   input  logic                       TROCA,
   input  logic [WIDTH-1:0]           DIN,
   output logic [WIDTH-1:0]           TOPO,
   output logic [WIDTH-1:0]           SEGUNDO,
   output logic [$clog2(DEPTH+1)-1:0] CONTAGEM,
   output logic                       VAZIA,
   output logic                       CHEIA,
   output logic                       ERRO
);

   localparam int CW = $clog2(DEPTH+1);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] ONE_C   = CW'(1);
   localparam logic [CW-1:0] TWO_C   = CW'(2);

   localparam logic [1:0] OP_NOP     = 2'b00;
   localparam logic [1:0] OP_PUSH    = 2'b01;
   localparam logic [1:0] OP_POP     = 2'b10;
   localparam logic [1:0] OP_REPLACE = 2'b11;

   // Entry 0 is the top; slots at or above the count are kept at zero.
   logic [WIDTH-1:0] ent_q [DEPTH];
   logic [WIDTH-1:0] ent_d [DEPTH];
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             erro_q, erro_d;
   logic             troca_act;

`ifdef PILHA_TROCA_EN
   assign troca_act = TROCA;
`else
   logic unused_troca;
   assign unused_troca = TROCA;
   assign troca_act    = 1'b0;
`endif

   always_comb begin
      for (int i = 0; i < DEPTH; i++) ent_d[i] = ent_q[i];
      cnt_d  = cnt_q;
      erro_d = erro_q;
      if (ENABLE) begin
         if (LIMPAR) begin
            for (int i = 0; i < DEPTH; i++) ent_d[i] = '0;
            cnt_d = '0;
         end else if (troca_act) begin
            if (cnt_q >= TWO_C) begin
               ent_d[0] = ent_q[1];
               ent_d[1] = ent_q[0];
            end else begin
               erro_d = 1'b1;
            end
         end else begin
            case (OP)
               OP_PUSH: begin
                  if (cnt_q < DEPTH_C) begin
                     for (int i = 1; i < DEPTH; i++) ent_d[i] = ent_q[i-1];
                     ent_d[0] = DIN;
                     cnt_d    = cnt_q + ONE_C;
                  end else begin
                     erro_d = 1'b1;
                  end
               end
               OP_POP: begin
                  if (cnt_q != '0) begin
                     for (int i = 0; i < DEPTH-1; i++) ent_d[i] = ent_q[i+1];
                     ent_d[DEPTH-1] = '0;
                     cnt_d          = cnt_q - ONE_C;
                  end else begin
                     erro_d = 1'b1;
                  end
               end
               OP_REPLACE: begin
                  // Two operands consumed, result written back as the new top.
                  if (cnt_q >= TWO_C) begin
                     for (int i = 1; i < DEPTH-1; i++) ent_d[i] = ent_q[i+1];
                     ent_d[DEPTH-1] = '0;
                     ent_d[0]       = DIN;
                     cnt_d          = cnt_q - ONE_C;
                  end else begin
                     erro_d = 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
         cnt_q  <= '0;
         erro_q <= 1'b0;
      end else begin
         for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
         cnt_q  <= cnt_d;
         erro_q <= erro_d;
      end
   end

   assign TOPO     = (cnt_q != '0)    ? ent_q[0] : '0;
   assign SEGUNDO  = (cnt_q >= TWO_C) ? ent_q[1] : '0;
   assign CONTAGEM = cnt_q;
   assign VAZIA    = (cnt_q == '0);
   assign CHEIA    = (cnt_q == DEPTH_C);
   assign ERRO     = erro_q;

endmodule

// File: tb/tb_pilha_rpn.sv
// Scoreboard bench for pilha_rpn (WIDTH=16, DEPTH=4) with directed, hand-computed vectors.
module tb_pilha_rpn;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        en  = 1'b0;
   logic        lim = 1'b0;
   logic        tro = 1'b0;
   logic [1:0]  op  = 2'b00;
   logic [15:0] din = 16'h0000;
   logic [15:0] topo, segundo;
   logic [2:0]  cont;
   logic        vazia, cheia, erro;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [15:0] topo;
      logic [15:0] seg;
      logic [2:0]  cnt;
      logic        vaz;
      logic        che;
      logic        err;
      string       nm;
   } exp_t;

   exp_t sb [$];

   pilha_rpn #(.WIDTH(16), .DEPTH(4)) dut (
      .CLOCK(clk), .RESET(rst), .ENABLE(en), .LIMPAR(lim), .OP(op), .TROCA(tro),
      .DIN(din), .TOPO(topo), .SEGUNDO(segundo), .CONTAGEM(cont),
      .VAZIA(vazia), .CHEIA(cheia), .ERRO(erro)
   );

   always #5 clk = ~clk;

   localparam logic [1:0] NOP = 2'b00, PSH = 2'b01, POP = 2'b10, REP = 2'b11;

   task automatic step(input logic r, input logic e, input logic l, input logic t,
                       input logic [1:0] o, input logic [15:0] d,
                       input logic [15:0] et, input logic [15:0] es, input logic [2:0] ec,
                       input logic ev, input logic eh, input logic ee, input string nm);
      exp_t x;
      @(negedge clk);
      rst = r; en = e; lim = l; tro = t; op = o; din = d;
      x.topo = et; x.seg = es; x.cnt = ec; x.vaz = ev; x.che = eh; x.err = ee; x.nm = nm;
      sb.push_back(x);
   endtask

   task automatic chk(input string nm, input string fld, input logic [15:0] act, input logic [15:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s.%s: got %h want %h", nm, fld, act, req);
      end
   endtask

   // Monitor: every cycle with a pending expectation, compare the registered outputs.
   initial begin
      exp_t x;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            x = sb.pop_front();
            chk(x.nm, "topo",  topo,           x.topo);
            chk(x.nm, "seg",   segundo,        x.seg);
            chk(x.nm, "cnt",   {13'd0, cont},  {13'd0, x.cnt});
            chk(x.nm, "vazia", {15'd0, vazia}, {15'd0, x.vaz});
            chk(x.nm, "cheia", {15'd0, cheia}, {15'd0, x.che});
            chk(x.nm, "erro",  {15'd0, erro},  {15'd0, x.err});
         end
      end
   end

   initial begin
      //    rst en lim tro op   din       topo      seg       cnt v  h  e
      step(1, 0, 0, 0, NOP, 16'h0000, 16'h0000, 16'h0000, 3'd0, 1, 0, 0, "reset");
      step(0, 1, 0, 0, PSH, 16'h0003, 16'h0003, 16'h0000, 3'd1, 0, 0, 0, "push3");
      step(0, 1, 0, 0, PSH, 16'h0004, 16'h0004, 16'h0003, 3'd2, 0, 0, 0, "push4");
      step(0, 1, 0, 0, REP, 16'h0007, 16'h0007, 16'h0000, 3'd1, 0, 0, 0, "rep7");
      step(0, 1, 1, 0, NOP, 16'h0000, 16'h0000, 16'h0000, 3'd0, 1, 0, 0, "clr");
      step(0, 1, 0, 0, PSH, 16'h0001, 16'h0001, 16'h0000, 3'd1, 0, 0, 0, "fill1");
      step(0, 1, 0, 0, PSH, 16'h0002, 16'h0002, 16'h0001, 3'd2, 0, 0, 0, "fill2");
      step(0, 1, 0, 0, PSH, 16'h0003, 16'h0003, 16'h0002, 3'd3, 0, 0, 0, "fill3");
      step(0, 1, 0, 0, PSH, 16'h0004, 16'h0004, 16'h0003, 3'd4, 0, 1, 0, "fill4");
      step(0, 1, 0, 0, PSH, 16'h0005, 16'h0004, 16'h0003, 3'd4, 0, 1, 1, "ovfl");
      step(0, 1, 0, 0, POP, 16'h0000, 16'h0003, 16'h0002, 3'd3, 0, 0, 1, "pop1");
      step(0, 1, 0, 0, POP, 16'h0000, 16'h0002, 16'h0001, 3'd2, 0, 0, 1, "pop2");
      step(0, 1, 0, 0, POP, 16'h0000, 16'h0001, 16'h0000, 3'd1, 0, 0, 1, "pop3");
      step(0, 1, 0, 0, POP, 16'h0000, 16'h0000, 16'h0000, 3'd0, 1, 0, 1, "pop4");
      step(0, 1, 0, 0, POP, 16'h0000, 16'h0000, 16'h0000, 3'd0, 1, 0, 1, "udfl");
      step(0, 1, 1, 0, NOP, 16'h0000, 16'h0000, 16'h0000, 3'd0, 1, 0, 1, "clr_keeps_erro");
      step(1, 1, 0, 0, PSH, 16'h0099, 16'h0000, 16'h0000, 3'd0, 1, 0, 0, "reset2");
      step(0, 1, 0, 0, PSH, 16'h0011, 16'h0011, 16'h0000, 3'd1, 0, 0, 0, "push11");
      step(0, 0, 0, 0, PSH, 16'h00AA, 16'h0011, 16'h0000, 3'd1, 0, 0, 0, "dis_push");
      step(0, 0, 1, 0, POP, 16'h0000, 16'h0011, 16'h0000, 3'd1, 0, 0, 0, "dis_clr");
      step(0, 1, 0, 0, NOP, 16'h00BB, 16'h0011, 16'h0000, 3'd1, 0, 0, 0, "nop");
      step(0, 1, 1, 0, PSH, 16'h00AA, 16'h0000, 16'h0000, 3'd0, 1, 0, 0, "clr_push");
      step(0, 1, 0, 0, PSH, 16'h0001, 16'h0001, 16'h0000, 3'd1, 0, 0, 0, "sw_p1");
      step(0, 1, 0, 0, PSH, 16'h0002, 16'h0002, 16'h0001, 3'd2, 0, 0, 0, "sw_p2");
`ifdef PILHA_TROCA_EN
      step(0, 1, 0, 1, POP, 16'h0000, 16'h0001, 16'h0002, 3'd2, 0, 0, 0, "troca_pop");
`else
      step(0, 1, 0, 1, POP, 16'h0000, 16'h0001, 16'h0000, 3'd1, 0, 0, 0, "troca_pop");
`endif
      step(1, 0, 0, 0, NOP, 16'h0000, 16'h0000, 16'h0000, 3'd0, 1, 0, 0, "reset3");
      step(0, 1, 0, 0, PSH, 16'h0010, 16'h0010, 16'h0000, 3'd1, 0, 0, 0, "d_p1");
      step(0, 1, 0, 0, PSH, 16'h0020, 16'h0020, 16'h0010, 3'd2, 0, 0, 0, "d_p2");
      step(0, 1, 0, 0, PSH, 16'h0030, 16'h0030, 16'h0020, 3'd3, 0, 0, 0, "d_p3");
      step(0, 1, 0, 0, REP, 16'h0050, 16'h0050, 16'h0010, 3'd2, 0, 0, 0, "rep_deep");
      step(0, 1, 0, 0, POP, 16'h0000, 16'h0010, 16'h0000, 3'd1, 0, 0, 0, "pop_deep");
      step(0, 1, 0, 0, REP, 16'h0009, 16'h0010, 16'h0000, 3'd1, 0, 0, 1, "rep_short");
      step(0, 1, 0, 0, PSH, 16'h0040, 16'h0040, 16'h0010, 3'd2, 0, 0, 1, "push_after_err");
      step(0, 1, 0, 0, PSH, 16'h0060, 16'h0060, 16'h0040, 3'd3, 0, 0, 1, "push3rd");
      step(1, 1, 0, 0, PSH, 16'h1234, 16'h0000, 16'h0000, 3'd0, 1, 0, 0, "reset_mid");
      step(0, 1, 0, 0, NOP, 16'h0000, 16'h0000, 16'h0000, 3'd0, 1, 0, 0, "after_reset");
      @(negedge clk);
      rst = 1'b0; en = 1'b0; lim = 1'b0; tro = 1'b0; op = NOP;
      repeat (3) @(posedge clk);
      #2;
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL drain: pending=%0d want 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
